// File: rtl/proc_rf_sched_if.sv
// Issue, writeback-arbitration and register-file write bundle
// for the scoreboard/writeback scheduler.
interface proc_rf_sched_if #(
  parameter int XLEN = 64
);
  logic            iss_valid;
  logic [4:0]      iss_rs1;
  logic [4:0]      iss_rs2;
  logic [4:0]      iss_rd;
  logic            iss_wen;
  logic            iss_stall;
  logic            alu_req;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_wdata;
  logic            alu_gnt;
  logic            lsu_req;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_wdata;
  logic            lsu_gnt;
  logic            rf_wen;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic            busy;
  logic [5:0]      pend_cnt;

  modport master (
    output iss_valid, iss_rs1, iss_rs2,
    output iss_rd, iss_wen,
    output alu_req, alu_rd, alu_wdata,
    output lsu_req, lsu_rd, lsu_wdata,
    input  iss_stall, alu_gnt, lsu_gnt,
    input  rf_wen, rf_rd, rf_wdata,
    input  busy, pend_cnt
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2,
    input  iss_rd, iss_wen,
    input  alu_req, alu_rd, alu_wdata,
    input  lsu_req, lsu_rd, lsu_wdata,
    output iss_stall, alu_gnt, lsu_gnt,
    output rf_wen, rf_rd, rf_wdata,
    output busy, pend_cnt
  );
endinterface

// File: rtl/proc_rf_sched.sv
// Register scoreboard with round-robin ALU/LSU writeback
// arbitration and a registered register-file write port.
module proc_rf_sched #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input logic            clk,
  input logic            nrst,
  proc_rf_sched_if.slave bus
);
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;
  logic            last_lsu;
  logic            alu_gnt;
  logic            lsu_gnt;
  logic            gnt;
  logic            stall;
  logic            accept;
  logic [4:0]      gnt_rd;
  logic [XLEN-1:0] gnt_wdata;
  logic [5:0]      cnt;
  logic            rf_wen;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;

  // Hazard check uses pre-edge pend, so a same-cycle clear still stalls.
  assign stall = nrst & bus.iss_valid &
                 (pend[bus.iss_rs1] | pend[bus.iss_rs2] |
                  (bus.iss_wen & pend[bus.iss_rd]));
  assign accept = nrst & bus.iss_valid & ~stall;

  // last_lsu=1 means LSU won most recently, so ALU wins the next tie.
  assign alu_gnt = nrst & bus.alu_req &
                   (~bus.lsu_req | last_lsu);
  assign lsu_gnt = nrst & bus.lsu_req &
                   (~bus.alu_req | ~last_lsu);
  assign gnt = alu_gnt | lsu_gnt;

  always_comb begin
    gnt_rd    = bus.lsu_rd;
    gnt_wdata = bus.lsu_wdata;
    if (alu_gnt) begin
      gnt_rd    = bus.alu_rd;
      gnt_wdata = bus.alu_wdata;
    end
  end

  always_comb begin
    pend_nxt = pend;
    if (rf_wen) pend_nxt[rf_rd] = 1'b0;
    if (accept && bus.iss_wen && bus.iss_rd != 5'd0)
      pend_nxt[bus.iss_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NREG; i++)
      cnt = cnt + 6'(pend[i]);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      pend     <= '0;
      last_lsu <= 1'b1;
      rf_wen   <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      pend   <= pend_nxt;
      rf_wen <= gnt & (gnt_rd != 5'd0);
      if (gnt) begin
        last_lsu <= lsu_gnt;
        rf_rd    <= gnt_rd;
        rf_wdata <= gnt_wdata;
      end
    end
  end

  assign bus.iss_stall = stall;
  assign bus.alu_gnt   = alu_gnt;
  assign bus.lsu_gnt   = lsu_gnt;
  assign bus.rf_wen    = rf_wen;
  assign bus.rf_rd     = rf_rd;
  assign bus.rf_wdata  = rf_wdata;
  assign bus.pend_cnt  = cnt;
  assign bus.busy      = (cnt != 6'd0);
endmodule

// File: tb/tb_proc_rf_sched.sv
// Directed bench for proc_rf_sched: scoreboard, arbitration,
// writeback latency, rd=0 handling and mid-request reset.
module tb_proc_rf_sched;
  logic clk;
  logic nrst;
  int   nvec;
  int   nerr;

  proc_rf_sched_if #(.XLEN(64)) bus ();

  proc_rf_sched #(
    .XLEN(64),
    .NREG(32)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Advance past a rising edge; inputs change and checks happen here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0;
    bus.iss_rs1   = '0;
    bus.iss_rs2   = '0;
    bus.iss_rd    = '0;
    bus.iss_wen   = 1'b0;
    bus.alu_req   = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_wdata = '0;
    bus.lsu_req   = 1'b0;
    bus.lsu_rd    = '0;
    bus.lsu_wdata = '0;
  endtask

  task automatic issue(input logic [4:0] rs1,
                       input logic [4:0] rs2,
                       input logic [4:0] rd);
    bus.iss_valid = 1'b1;
    bus.iss_rs1   = rs1;
    bus.iss_rs2   = rs2;
    bus.iss_rd    = rd;
    bus.iss_wen   = 1'b1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    idle();
    nrst = 1'b0;
    step();
    step();
    chk("rst_cnt", 64'(bus.pend_cnt), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_wen", 64'(bus.rf_wen), 64'd0);
    chk("rst_rd", 64'(bus.rf_rd), 64'd0);
    chk("rst_wdata", bus.rf_wdata, 64'd0);

    // Issue rd=5, then a reader of x5 stalls until writeback.
    nrst = 1'b1;
    issue(5'd0, 5'd0, 5'd5);
    settle();
    chk("iss5_stall", 64'(bus.iss_stall), 64'd0);
    step();
    chk("iss5_cnt", 64'(bus.pend_cnt), 64'd1);
    chk("iss5_busy", 64'(bus.busy), 64'd1);
    issue(5'd5, 5'd0, 5'd6);
    settle();
    chk("raw_stall0", 64'(bus.iss_stall), 64'd1);
    step();
    chk("raw_stall1", 64'(bus.iss_stall), 64'd1);
    bus.alu_req   = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_wdata = 64'hDEAD;
    settle();
    chk("alu_gnt_n", 64'(bus.alu_gnt), 64'd1);
    chk("lsu_gnt_n", 64'(bus.lsu_gnt), 64'd0);
    step();
    bus.alu_req = 1'b0;
    settle();
    chk("wb_wen", 64'(bus.rf_wen), 64'd1);
    chk("wb_rd", 64'(bus.rf_rd), 64'd5);
    chk("wb_wdata", bus.rf_wdata, 64'hDEAD);
    chk("wb_stall", 64'(bus.iss_stall), 64'd1);
    chk("wb_cnt", 64'(bus.pend_cnt), 64'd1);
    step();
    chk("clr_wen", 64'(bus.rf_wen), 64'd0);
    chk("clr_cnt", 64'(bus.pend_cnt), 64'd0);
    chk("clr_stall", 64'(bus.iss_stall), 64'd0);
    step();
    idle();
    chk("iss6_cnt", 64'(bus.pend_cnt), 64'd1);

    // LSU-only writeback of x6.
    bus.lsu_req   = 1'b1;
    bus.lsu_rd    = 5'd6;
    bus.lsu_wdata = 64'h1234;
    settle();
    chk("lsu6_gnt", 64'(bus.lsu_gnt), 64'd1);
    chk("lsu6_agnt", 64'(bus.alu_gnt), 64'd0);
    step();
    idle();
    settle();
    chk("lsu6_wen", 64'(bus.rf_wen), 64'd1);
    chk("lsu6_rd", 64'(bus.rf_rd), 64'd6);
    chk("lsu6_wdata", bus.rf_wdata, 64'h1234);
    step();
    chk("lsu6_cnt", 64'(bus.pend_cnt), 64'd0);
    chk("hold_wen", 64'(bus.rf_wen), 64'd0);
    chk("hold_rd", 64'(bus.rf_rd), 64'd6);
    chk("hold_wdata", bus.rf_wdata, 64'h1234);

    // Round-robin after reset: ALU, LSU, ALU, LSU.
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    bus.alu_req   = 1'b1;
    bus.alu_rd    = 5'd1;
    bus.alu_wdata = 64'hA;
    bus.lsu_req   = 1'b1;
    bus.lsu_rd    = 5'd2;
    bus.lsu_wdata = 64'hB;
    settle();
    chk("rr0_alu", 64'(bus.alu_gnt), 64'd1);
    chk("rr0_lsu", 64'(bus.lsu_gnt), 64'd0);
    step();
    chk("rr1_alu", 64'(bus.alu_gnt), 64'd0);
    chk("rr1_lsu", 64'(bus.lsu_gnt), 64'd1);
    chk("rr1_wen", 64'(bus.rf_wen), 64'd1);
    chk("rr1_rd", 64'(bus.rf_rd), 64'd1);
    chk("rr1_wdata", bus.rf_wdata, 64'hA);
    step();
    chk("rr2_alu", 64'(bus.alu_gnt), 64'd1);
    chk("rr2_lsu", 64'(bus.lsu_gnt), 64'd0);
    chk("rr2_rd", 64'(bus.rf_rd), 64'd2);
    chk("rr2_wdata", bus.rf_wdata, 64'hB);
    step();
    chk("rr3_alu", 64'(bus.alu_gnt), 64'd0);
    chk("rr3_lsu", 64'(bus.lsu_gnt), 64'd1);
    step();

    // rd=0 writeback is consumed without a write.
    idle();
    bus.lsu_req   = 1'b1;
    bus.lsu_rd    = 5'd0;
    bus.lsu_wdata = 64'h55;
    settle();
    chk("rd0_gnt", 64'(bus.lsu_gnt), 64'd1);
    step();
    idle();
    settle();
    chk("rd0_wen", 64'(bus.rf_wen), 64'd0);
    chk("rd0_rd", 64'(bus.rf_rd), 64'd0);
    chk("rd0_wdata", bus.rf_wdata, 64'h55);
    chk("rd0_cnt", 64'(bus.pend_cnt), 64'd0);
    issue(5'd0, 5'd0, 5'd0);
    settle();
    chk("iss0_stall", 64'(bus.iss_stall), 64'd0);
    step();
    idle();
    chk("iss0_cnt", 64'(bus.pend_cnt), 64'd0);

    // Reset pulse with pending registers and a live request.
    issue(5'd0, 5'd0, 5'd3);
    step();
    issue(5'd0, 5'd0, 5'd7);
    step();
    idle();
    chk("pre_cnt", 64'(bus.pend_cnt), 64'd2);
    bus.alu_req   = 1'b1;
    bus.alu_rd    = 5'd3;
    bus.alu_wdata = 64'hCAFE;
    issue(5'd3, 5'd0, 5'd9);
    nrst = 1'b0;
    settle();
    chk("rstm_agnt", 64'(bus.alu_gnt), 64'd0);
    chk("rstm_lgnt", 64'(bus.lsu_gnt), 64'd0);
    chk("rstm_stall", 64'(bus.iss_stall), 64'd0);
    step();
    idle();
    nrst = 1'b1;
    settle();
    chk("rstm_cnt", 64'(bus.pend_cnt), 64'd0);
    chk("rstm_busy", 64'(bus.busy), 64'd0);
    chk("rstm_wen", 64'(bus.rf_wen), 64'd0);
    chk("rstm_rd", 64'(bus.rf_rd), 64'd0);
    step();
    chk("post_wen", 64'(bus.rf_wen), 64'd0);
    chk("post_cnt", 64'(bus.pend_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule

// File: doc/proc_rf_sched.md
PROC_RF_SCHED -- requirements
Module: proc_rf_sched

Interface
REQ-001 The block SHALL have parameter XLEN, default 64: width of write data.
REQ-002 The block SHALL have parameter NREG, default 32: number of architectural registers; register index width is 5.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 nrst  in  1  reset, synchronous and active-low.
REQ-005 iss_valid  in  1  decode presents an instruction for issue.
REQ-006 iss_rs1, iss_rs2  in  5 each  source register indices of the issuing instruction.
REQ-007 iss_rd  in  5  destination index; iss_wen  in  1  instruction writes iss_rd.
REQ-008 iss_stall  out  1  instruction not accepted this cycle; decode holds its inputs.
REQ-009 alu_req  in  1; alu_rd  in  5; alu_wdata  in  XLEN  ALU writeback request.
REQ-010 alu_gnt  out  1  ALU request consumed this cycle.
REQ-011 lsu_req  in  1; lsu_rd  in  5; lsu_wdata  in  XLEN  load-unit writeback request.
REQ-012 lsu_gnt  out  1  LSU request consumed this cycle.
REQ-013 rf_wen  out  1; rf_rd  out  5; rf_wdata  out  XLEN  registered drive of the register-file write port.
REQ-014 busy  out  1  at least one scoreboard bit set; pend_cnt  out  6  number of set scoreboard bits.

Function
REQ-015 The block SHALL keep a 32-bit scoreboard pend[31:0]; pend[0] SHALL be constant 0.
REQ-016 iss_stall SHALL be combinational: iss_valid AND (pend[iss_rs1] OR pend[iss_rs2] OR (iss_wen AND pend[iss_rd])).
REQ-017 Issue is accepted when iss_valid=1 and iss_stall=0; on that edge pend[iss_rd] SHALL be set if iss_wen=1 and iss_rd!=0.
REQ-018 Arbitration: single requester SHALL be granted in the same cycle; both requesting SHALL grant the one not granted most recently (round-robin, 1-bit last-grant pointer updated only on a grant).
REQ-019 At most one of alu_gnt/lsu_gnt SHALL be high per cycle; gnt SHALL be 0 when the matching req is 0.
REQ-020 Requesters SHALL hold req, rd, wdata stable until granted; the block SHALL NOT sample them otherwise.
REQ-021 On the edge of a grant, rf_rd/rf_wdata SHALL load the granted rd/wdata and rf_wen SHALL load 1 if granted rd!=0, else 0 (rd=0 request is consumed, no write); with no grant rf_wen SHALL load 0 and rf_rd/rf_wdata hold.
REQ-022 Latency: grant at cycle N -> rf_wen high during cycle N+1 -> register file updated at end of N+1.
REQ-023 On each edge where rf_wen=1, pend[rf_rd] SHALL be cleared, so a dependent instruction sees iss_stall=0 only once the register file holds the new value.
REQ-024 Same-cycle clear of pend[x] and issue of an instruction reading x: iss_stall uses pre-edge pend, so the instruction stalls one more cycle; no set/clear conflict arises since WAW stalls.
REQ-025 A grant for an rd whose pend bit is clear SHALL still write; the clear is a no-op.
REQ-026 pend_cnt SHALL equal popcount(pend) at all times, range 0..31, no wrap; busy = (pend_cnt!=0).

Reset
REQ-027 With nrst=0 at an edge: pend=0, rf_wen=0, rf_rd=0, rf_wdata=0, last-grant pointer=LSU (ALU wins first tie), regardless of activity in progress.
REQ-028 While nrst=0, alu_gnt, lsu_gnt and iss_stall SHALL be 0 and no issue SHALL be accepted; in-flight requests are dropped.

Verification
REQ-029 Reset then issue rd=5 wen=1 -> pend[5]=1, pend_cnt=1; next issue rs1=5 -> iss_stall=1 until edge after rf_wen=1 with rf_rd=5.
REQ-030 alu_req rd=5 wdata=0xDEAD at cycle N -> alu_gnt=1 at N; rf_wen=1, rf_rd=5, rf_wdata=0xDEAD at N+1; pend[5]=0 at N+2.
REQ-031 alu_req and lsu_req held together 4 cycles after reset -> grants ALU, LSU, ALU, LSU; never both high.
REQ-032 lsu_req rd=0 -> lsu_gnt=1, rf_wen stays 0, pend unchanged; issue rd=0 wen=1 -> pend unchanged, no stall.
REQ-033 Issue rd=3 and rd=7, pulse nrst=0 one cycle mid-request -> pend=0, pend_cnt=0, rf_wen=0, grants 0 during reset.
